bus_trace_dumper: RTL and testbench

BUS_TRACE_DUMPER -- requirements
Module: bus_trace_dumper

---
 rtl/bus_trace_pkg.sv | 32 +++
 rtl/bus_trace_dumper.sv | 179 +++++++++++++++++
 tb/tb_bus_trace_dumper.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_trace_pkg.sv
// Shared constants for the bus trace dumper: mode encodings, ASCII codes,
// FSM state encodings and the nibble-to-hex-character helper.
package bus_trace_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_DRAIN = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_CONT  = 2'd3;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_ONE   = 8'h31;
  localparam logic [7:0] ASC_A     = 8'h41;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HEX   = 3'd2;
  localparam logic [2:0] ST_SPACE = 3'd3;
  localparam logic [2:0] ST_FLAG  = 3'd4;
  localparam logic [2:0] ST_CR    = 3'd5;
  localparam logic [2:0] ST_LF    = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  // Uppercase hex character for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASC_ZERO + {4'h0, nib};
    else             return ASC_A + {4'h0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/bus_trace_dumper.sv
// Bus trace dumper: pulls fixed-format records from a source and streams
// them out as ASCII lines "WORD0 WORD1 ... FLAGS\r\n", one byte per handshake.
module bus_trace_dumper
  import bus_trace_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int WORDS    = 2,
  parameter int FLAGS    = 1,
  parameter int COUNTW   = 16
) (
  input  logic                            comm_clock,
  input  logic                            reset,
  input  logic                            dump_start,
  input  logic                            dump_abort,
  input  logic [1:0]                      dump_mode,
  input  logic [COUNTW-1:0]               dump_count,
  output logic                            dump_end,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WORDS*BITWIDTH+FLAGS-1:0] in_data,
  input  logic                            in_empty,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_data,
  output logic                            busy
);

  localparam int NIBS  = BITWIDTH / 4;
  localparam int WBITS = WORDS * BITWIDTH;
  localparam int DIG_W = (NIBS  > 1) ? $clog2(NIBS)  : 1;
  localparam int WRD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FLG_W = (FLAGS > 1) ? $clog2(FLAGS) : 1;

  logic [2:0]        state;
  logic [1:0]        mode_q;
  logic [COUNTW-1:0] remain;
  logic              abort_pend;
  logic [DIG_W-1:0]  digit_idx;
  logic [WRD_W-1:0]  word_idx;
  logic [FLG_W-1:0]  flag_idx;

  // Word 0 sits in the top slot so a plain left shift walks every digit of
  // every word in output order; the current digit is always the top nibble.
  logic [WBITS-1:0]  words_rev;
  logic [WBITS-1:0]  words_sh;
  logic [FLAGS-1:0]  flag_sh;
  logic              capture;
  logic              accept;

  for (genvar k = 0; k < WORDS; k++) begin : g_rev
    assign words_rev[(WORDS-1-k)*BITWIDTH +: BITWIDTH] = in_data[k*BITWIDTH +: BITWIDTH];
  end

  // A pending abort closes the source side so no new record is taken.
  assign in_ready  = (state == ST_FETCH) && !abort_pend;
  assign capture   = in_valid && in_ready;
  assign out_valid = (state == ST_HEX) || (state == ST_SPACE) || (state == ST_FLAG) ||
                     (state == ST_CR)  || (state == ST_LF);
  assign accept    = out_valid && out_ready;
  assign busy      = (state != ST_IDLE);
  assign dump_end  = (state == ST_DONE);

  // Output byte is a pure function of state and the shifting record, so it
  // holds still for as long as the sink stalls.
  always_comb begin
    out_data = 8'h00;
    case (state)
      ST_HEX:   out_data = nib2ascii(words_sh[WBITS-1 -: 4]);
      ST_SPACE: out_data = ASC_SPACE;
      ST_FLAG:  out_data = flag_sh[FLAGS-1] ? ASC_ONE : ASC_ZERO;
      ST_CR:    out_data = ASC_CR;
      ST_LF:    out_data = ASC_LF;
      default:  out_data = 8'h00;
    endcase
  end

  // Control FSM, counters and abort latch.
  always_ff @(posedge comm_clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_OFF;
      remain     <= '0;
      abort_pend <= 1'b0;
      digit_idx  <= '0;
      word_idx   <= '0;
      flag_idx   <= '0;
    end else begin
      if (dump_abort && (state != ST_IDLE) && (state != ST_DONE)) abort_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (dump_start && (dump_mode != MODE_OFF)) begin
            mode_q <= dump_mode;
            remain <= dump_count;
            state  <= ((dump_mode == MODE_COUNT) && (dump_count == '0)) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (abort_pend) begin
            state <= ST_DONE;
          end else if (in_valid) begin
            state     <= ST_HEX;
            digit_idx <= '0;
            word_idx  <= '0;
            flag_idx  <= '0;
          end else if ((mode_q == MODE_DRAIN) && in_empty) begin
            state <= ST_DONE;
          end
        end
        ST_HEX: begin
          if (accept) begin
            if (digit_idx == DIG_W'(NIBS-1)) begin
              digit_idx <= '0;
              state     <= ST_SPACE;
            end else begin
              digit_idx <= digit_idx + DIG_W'(1);
            end
          end
        end
        ST_SPACE: begin
          if (accept) begin
            if (word_idx == WRD_W'(WORDS-1)) begin
              word_idx <= '0;
              state    <= ST_FLAG;
            end else begin
              word_idx <= word_idx + WRD_W'(1);
              state    <= ST_HEX;
            end
          end
        end
        ST_FLAG: begin
          if (accept) begin
            if (flag_idx == FLG_W'(FLAGS-1)) begin
              flag_idx <= '0;
              state    <= ST_CR;
            end else begin
              flag_idx <= flag_idx + FLG_W'(1);
            end
          end
        end
        ST_CR: begin
          if (accept) state <= ST_LF;
        end
        ST_LF: begin
          if (accept) begin
            if (abort_pend || dump_abort) begin
              state <= ST_DONE;
            end else begin
              case (mode_q)
                MODE_COUNT: begin
                  remain <= remain - COUNTW'(1);
                  state  <= (remain == COUNTW'(1)) ? ST_DONE : ST_FETCH;
                end
                MODE_DRAIN, MODE_CONT: state <= ST_FETCH;
                default:               state <= ST_FETCH;
              endcase
            end
          end
        end
        ST_DONE: begin
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Record shift registers: loaded on capture, shifted as bytes leave.
  always_ff @(posedge comm_clock) begin
    if (capture) begin
      words_sh <= words_rev;
      flag_sh  <= in_data[WBITS +: FLAGS];
    end else begin
      if ((state == ST_HEX) && accept)  words_sh <= words_sh << 4;
      if ((state == ST_FLAG) && accept) flag_sh  <= flag_sh << 1;
    end
  end

endmodule

// File: tb/tb_bus_trace_dumper.sv
// Directed bench for bus_trace_dumper (BITWIDTH=32, WORDS=2, FLAGS=1).
// Bytes are rendered with CR as '~' and LF as '|' so lines compare as text.
module tb_bus_trace_dumper;

  logic        comm_clock = 1'b0;
  logic        reset;
  logic        dump_start;
  logic        dump_abort;
  logic [1:0]  dump_mode;
  logic [15:0] dump_count;
  logic        dump_end;
  logic        in_valid;
  logic        in_ready;
  logic [64:0] in_data;
  logic        in_empty;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  bus_trace_dumper #(.BITWIDTH(32), .WORDS(2), .FLAGS(1), .COUNTW(16)) dut (
    .comm_clock(comm_clock), .reset(reset),
    .dump_start(dump_start), .dump_abort(dump_abort),
    .dump_mode(dump_mode), .dump_count(dump_count), .dump_end(dump_end),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 comm_clock = ~comm_clock;

  int total = 0;
  int bad   = 0;

  logic [7:0]  got[$];
  logic [64:0] recs[$];
  int   end_pulses, accepts, ready_seen, stall_err, stalls;
  bit   stall_pending;
  logic [7:0] stall_byte;
  bit   start_req, abort_req;

  function automatic logic [64:0] mk(input logic [31:0] w0, input logic [31:0] w1, input logic f);
    return {f, w1, w0};
  endfunction

  function automatic string q2s();
    string s = "";
    foreach (got[i]) begin
      if (got[i] == 8'h0D)      s = {s, "~"};
      else if (got[i] == 8'h0A) s = {s, "|"};
      else                      s = {s, $sformatf("%c", got[i])};
    end
    return s;
  endfunction

  task automatic clear_obs();
    got.delete();
    end_pulses = 0; accepts = 0; ready_seen = 0;
    stall_err = 0; stalls = 0; stall_pending = 0;
  endtask

  task automatic start(input logic [1:0] m, input logic [15:0] c);
    dump_mode = m; dump_count = c; start_req = 1;
  endtask

  // One clock of stimulus and observation: drive at negedge, observe at +1.
  task automatic cycle(input bit rnd);
    @(negedge comm_clock);
    dump_start = start_req; start_req = 0;
    dump_abort = abort_req; abort_req = 0;
    out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (recs.size() > 0) begin in_valid = 1'b1; in_data = recs[0]; end
    else                 begin in_valid = 1'b0; end
    #1;
    if (dump_end) end_pulses++;
    if (in_ready) ready_seen++;
    if (in_valid && in_ready) begin void'(recs.pop_front()); accepts++; end
    if (stall_pending && out_valid && (out_data !== stall_byte)) stall_err++;
    if (out_valid && out_ready) begin
      got.push_back(out_data); stall_pending = 0;
    end else if (out_valid) begin
      stalls++; stall_pending = 1; stall_byte = out_data;
    end else begin
      stall_pending = 0;
    end
  endtask

  task automatic run(input int budget, input bit rnd, input int abort_at, input int start_at,
                     input int stop_at, input logic [1:0] smode, input logic [15:0] scount,
                     output bit timed_out, output int used);
    bit ab_done = 0;
    bit st_done = 0;
    timed_out = 1; used = budget;
    for (int c = 0; c < budget; c++) begin
      cycle(rnd);
      if (!ab_done && abort_at >= 0 && got.size() == abort_at) begin abort_req = 1; ab_done = 1; end
      if (!st_done && start_at >= 0 && got.size() == start_at) begin
        dump_mode = smode; dump_count = scount; start_req = 1; st_done = 1;
      end
      if (stop_at >= 0 && got.size() >= stop_at) begin timed_out = 0; used = c + 1; return; end
      if (end_pulses > 0) begin timed_out = 0; used = c + 1; break; end
    end
    repeat (3) cycle(rnd);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = mk(32'h1, 32'h2, 1'b1);
    repeat (2) @(negedge comm_clock);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (dump_end !== 1'b0) begin bad++; $display("FAIL reset_dump_end: got %b want 0", dump_end); end
    in_valid = 1'b0;
    @(negedge comm_clock); reset = 1'b1;
  endtask

  task automatic test_count_one();
    bit to; int used; string s;
    clear_obs();
    recs.push_back(mk(32'h12ABCDEF, 32'h000000FF, 1'b1));
    start(2'd2, 16'd1);
    run(200, 0, -1, -1, -1, 2'd0, 16'd0, to, used);
    s = q2s();
    total++; if (to) begin bad++; $display("FAIL count1_timeout: no dump_end within 200 cycles"); end
    total++; if (s != "12ABCDEF 000000FF 1~|") begin bad++; $display("FAIL count1_bytes: got '%s' want '12ABCDEF 000000FF 1~|'", s); end
    total++; if (got.size() != 21) begin bad++; $display("FAIL count1_len: got %0d want 21", got.size()); end
    total++; if (end_pulses != 1) begin bad++; $display("FAIL count1_end_pulses: got %0d want 1", end_pulses); end
    total++; if (accepts != 1) begin bad++; $display("FAIL count1_accepts: got %0d want 1", accepts); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL count1_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_random_stall();
    bit to; int used; string s;
    clear_obs();
    recs.push_back(mk(32'h12ABCDEF, 32'h000000FF, 1'b1));
    start(2'd2, 16'd1);
    run(400, 1, -1, -1, -1, 2'd0, 16'd0, to, used);
    s = q2s();
    total++; if (to) begin bad++; $display("FAIL stall_timeout: no dump_end within 400 cycles"); end
    total++; if (s != "12ABCDEF 000000FF 1~|") begin bad++; $display("FAIL stall_bytes: got '%s' want '12ABCDEF 000000FF 1~|'", s); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL stall_hold: %0d changes of out_data during stalls, want 0", stall_err); end
    total++; if (stalls == 0) begin bad++; $display("FAIL stall_exercised: got %0d stalls want >0", stalls); end
    total++; if (end_pulses != 1) begin bad++; $display("FAIL stall_end_pulses: got %0d want 1", end_pulses); end
  endtask

  task automatic test_drain();
    bit to; int used; string s;
    clear_obs();
    recs.push_back(mk(32'hDEADBEEF, 32'h00000001, 1'b0));
    recs.push_back(mk(32'h00000000, 32'hFFFFFFFF, 1'b1));
    recs.push_back(mk(32'h89ABCDEF, 32'h01234567, 1'b0));
    in_empty = 1'b1;
    start(2'd1, 16'd0);
    run(400, 0, -1, -1, -1, 2'd0, 16'd0, to, used);
    s = q2s();
    total++; if (to) begin bad++; $display("FAIL drain_timeout: no dump_end within 400 cycles"); end
    total++; if (s != "DEADBEEF 00000001 0~|00000000 FFFFFFFF 1~|89ABCDEF 01234567 0~|") begin
      bad++; $display("FAIL drain_bytes: got '%s' want 'DEADBEEF 00000001 0~|00000000 FFFFFFFF 1~|89ABCDEF 01234567 0~|'", s);
    end
    total++; if (got.size() != 63) begin bad++; $display("FAIL drain_len: got %0d want 63", got.size()); end
    total++; if (accepts != 3) begin bad++; $display("FAIL drain_accepts: got %0d want 3", accepts); end
    total++; if (end_pulses != 1) begin bad++; $display("FAIL drain_end_pulses: got %0d want 1", end_pulses); end
    in_empty = 1'b0;
  endtask

  task automatic test_count_zero();
    bit to; int used;
    clear_obs();
    recs.push_back(mk(32'h11111111, 32'h22222222, 1'b1));
    start(2'd2, 16'd0);
    run(20, 0, -1, -1, -1, 2'd0, 16'd0, to, used);
    total++; if (to || used > 2) begin bad++; $display("FAIL count0_latency: got %0d cycles (timeout=%0d) want <=2", used, to); end
    total++; if (got.size() != 0) begin bad++; $display("FAIL count0_bytes: got %0d bytes want 0", got.size()); end
    total++; if (ready_seen != 0) begin bad++; $display("FAIL count0_in_ready: got %0d cycles want 0", ready_seen); end
    total++; if (end_pulses != 1) begin bad++; $display("FAIL count0_end_pulses: got %0d want 1", end_pulses); end
    // Mode 0 start is ignored entirely.
    clear_obs();
    start(2'd0, 16'd3);
    repeat (3) cycle(0);
    total++; if (busy !== 1'b0 || ready_seen != 0) begin bad++; $display("FAIL mode0_ignored: busy=%b ready_cycles=%0d want 0/0", busy, ready_seen); end
    recs.delete();
  endtask

  task automatic test_abort();
    bit to; int used; string s;
    clear_obs();
    recs.push_back(mk(32'hCAFEF00D, 32'h00C0FFEE, 1'b1));
    recs.push_back(mk(32'hCAFEF00D, 32'h00C0FFEE, 1'b1));
    start(2'd3, 16'd0);
    run(300, 0, 5, -1, -1, 2'd0, 16'd0, to, used);
    s = q2s();
    total++; if (to) begin bad++; $display("FAIL abort_timeout: no dump_end within 300 cycles"); end
    total++; if (s != "CAFEF00D 00C0FFEE 1~|") begin bad++; $display("FAIL abort_bytes: got '%s' want 'CAFEF00D 00C0FFEE 1~|'", s); end
    total++; if (ready_seen != 1) begin bad++; $display("FAIL abort_in_ready: got %0d cycles want 1", ready_seen); end
    total++; if (recs.size() != 1) begin bad++; $display("FAIL abort_left: got %0d records left want 1", recs.size()); end
    total++; if (end_pulses != 1) begin bad++; $display("FAIL abort_end_pulses: got %0d want 1", end_pulses); end
    recs.delete();
  endtask

  task automatic test_reset_mid();
    bit to; int used; string s;
    clear_obs();
    recs.push_back(mk(32'h76543210, 32'hFEDCBA98, 1'b1));
    start(2'd2, 16'd1);
    run(200, 0, -1, -1, 10, 2'd0, 16'd0, to, used);
    total++; if (to) begin bad++; $display("FAIL rstmid_reach: byte 10 not reached"); end
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    repeat (3) @(negedge comm_clock);
    reset = 1'b1;
    clear_obs();
    recs.push_back(mk(32'h55AA55AA, 32'h0F0F0F0F, 1'b0));
    start(2'd2, 16'd1);
    run(200, 0, -1, -1, -1, 2'd0, 16'd0, to, used);
    s = q2s();
    total++; if (to) begin bad++; $display("FAIL rstmid_timeout: no dump_end after restart"); end
    total++; if (s != "55AA55AA 0F0F0F0F 0~|") begin bad++; $display("FAIL rstmid_bytes: got '%s' want '55AA55AA 0F0F0F0F 0~|'", s); end
  endtask

  task automatic test_back_to_back_start();
    bit to; int used; string s;
    clear_obs();
    recs.push_back(mk(32'h00000000, 32'h00000000, 1'b1));
    recs.push_back(mk(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0));
    recs.push_back(mk(32'h33333333, 32'h44444444, 1'b1));
    start(2'd2, 16'd2);
    run(400, 0, -1, 8, -1, 2'd2, 16'd5, to, used);
    s = q2s();
    total++; if (to) begin bad++; $display("FAIL busystart_timeout: no dump_end within 400 cycles"); end
    total++; if (s != "00000000 00000000 1~|A5A5A5A5 5A5A5A5A 0~|") begin
      bad++; $display("FAIL busystart_bytes: got '%s' want '00000000 00000000 1~|A5A5A5A5 5A5A5A5A 0~|'", s);
    end
    total++; if (accepts != 2) begin bad++; $display("FAIL busystart_accepts: got %0d want 2", accepts); end
    total++; if (end_pulses != 1) begin bad++; $display("FAIL busystart_end_pulses: got %0d want 1", end_pulses); end
    total++; if (recs.size() != 1) begin bad++; $display("FAIL busystart_left: got %0d records left want 1", recs.size()); end
    recs.delete();
  endtask

  initial begin
    reset = 1'b0; dump_start = 1'b0; dump_abort = 1'b0; dump_mode = 2'd0; dump_count = 16'd0;
    in_valid = 1'b0; in_data = '0; in_empty = 1'b0; out_ready = 1'b1;
    start_req = 0; abort_req = 0;
    clear_obs();
    test_reset();
    test_count_one();
    test_random_stall();
    test_drain();
    test_count_zero();
    test_abort();
    test_reset_mid();
    test_back_to_back_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
